// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetch queue: FIFO entry layout and word helpers.
package prefetch_pkg;
  localparam int INST_WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/prefetch_fifo.sv
// Circular buffer of fetch entries; flush empties it in one cycle, head is read combinationally.
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_head,
  output logic [AW:0]  o_count
);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;

  // Storage is not reset; validity is tracked entirely by r_count.
  always_ff @(posedge clock)
    if (i_push) r_mem[r_tail] <= i_wdata;

  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock)
    if (!reset && !i_flush)
      assert (!(i_push && !i_pop && r_count == (AW+1)'(DEPTH)));

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
endmodule

// File: rtl/prefetch_queue.sv
// Fetch PC owner and prefetch buffer feeding decode. Optional perf counters: PREFETCH_PERF_EN.
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_empty_cycles
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_fetch_pc, r_inflight_pc;
  logic          r_inflight;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_used, w_limit;
  logic          w_valid, w_pop, w_push, w_issue;
  fetch_entry_t  w_head, w_wdata;

  assign w_valid = !reset && (w_count != '0);
  assign w_pop   = w_valid && out_ready && !redirect;
  assign w_push  = !reset && !redirect && r_inflight;
  // A pop this cycle frees a slot, so issue can resume in the same cycle decode unstalls.
  assign w_used  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_limit = (CW+1)'(DEPTH) + {{CW{1'b0}}, w_pop};
  assign w_issue = !reset && !redirect && (w_used < w_limit);

  assign w_wdata = '{pc: r_inflight_pc, inst: imem_rdata};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= word_align(redirect_pc);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'(INST_WORD_BYTES);
      end
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign imem_req  = w_issue;
  assign imem_addr = reset ? RESET_PC : r_fetch_pc;
  assign out_valid = w_valid;
  assign out_pc    = reset ? 32'h0 : w_head.pc;
  assign out_inst  = reset ? 32'h0 : w_head.inst;

`ifdef PREFETCH_PERF_EN
  logic [31:0] r_perf_redirects, r_perf_empty;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_redirects <= '0;
      r_perf_empty     <= '0;
    end else begin
      if (redirect)              r_perf_redirects <= r_perf_redirects + 32'd1;
      if (out_ready && !w_valid) r_perf_empty     <= r_perf_empty + 32'd1;
    end
  end
  assign perf_redirects    = r_perf_redirects;
  assign perf_empty_cycles = r_perf_empty;
`else
  assign perf_redirects    = 32'h0;
  assign perf_empty_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue; imem model returns the request address as data.
module tb_prefetch_queue;
  logic        clock = 1'b0;
  logic        reset, imem_req, redirect, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_pc, out_inst;
  logic [31:0] perf_redirects, perf_empty_cycles;
  int          checks = 0, errors = 0;
  int          nreq;
  logic [31:0] last_addr, exp_redir, exp_empty;

  always #5 clock = ~clock;

  always @(posedge clock)
    imem_rdata <= imem_req ? imem_addr : 32'hBAD0_BAD0;

  prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .perf_redirects(perf_redirects), .perf_empty_cycles(perf_empty_cycles)
  );

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h500; out_ready = 1'b1;
    tick(); tick();
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req",   {31'd0, imem_req},  32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_pc",    out_pc,    32'h0);
    chk("rst_inst",  out_inst,  32'h0);

    // cycle 0: reset released, redirect held during reset must be ignored
    reset = 1'b0; redirect = 1'b0; #1;
    chk("c0_req",   {31'd0, imem_req},  32'd1);
    chk("c0_addr",  imem_addr, 32'h0);
    chk("c0_valid", {31'd0, out_valid}, 32'd0);
    chk("c0_perf_r", perf_redirects,    32'd0);
    chk("c0_perf_e", perf_empty_cycles, 32'd0);
    tick(); #1;
    chk("c1_valid", {31'd0, out_valid}, 32'd0);
    chk("c1_addr",  imem_addr, 32'h4);
    tick(); #1;
    chk("c2_valid", {31'd0, out_valid}, 32'd1);
    chk("c2_pc",    out_pc,   32'h0);
    chk("c2_inst",  out_inst, 32'h0);
    tick(); #1; chk("c3_pc", out_pc, 32'h4);
    tick(); #1; chk("c4_pc", out_pc, 32'h8);

    // cycle 5: redirect to 0x100 while queue holds 0xC
    tick(); redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk("c5_pc",  out_pc, 32'hC);
    chk("c5_req", {31'd0, imem_req}, 32'd0);
    tick(); redirect = 1'b0; #1;
    chk("c6_valid", {31'd0, out_valid}, 32'd0);
    chk("c6_req",   {31'd0, imem_req},  32'd1);
    chk("c6_addr",  imem_addr, 32'h100);
    tick(); #1; chk("c7_valid", {31'd0, out_valid}, 32'd0);
    tick(); #1;
    chk("c8_valid", {31'd0, out_valid}, 32'd1);
    chk("c8_pc",    out_pc,   32'h100);
    chk("c8_inst",  out_inst, 32'h100);
    tick(); #1; chk("c9_pc", out_pc, 32'h104);

    // misaligned target is word-aligned
    tick(); redirect = 1'b1; redirect_pc = 32'h203; #1;
    tick(); redirect = 1'b0; #1; chk("r203_addr", imem_addr, 32'h200);
    tick(); #1; chk("r203_gap", {31'd0, out_valid}, 32'd0);
    tick(); #1;
    chk("r203_valid", {31'd0, out_valid}, 32'd1);
    chk("r203_pc",    out_pc, 32'h200);

    // stall: restart at 0 with decode stalled for 10 cycles
    tick(); redirect = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0; #1;
    nreq = 0; last_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      tick(); redirect = 1'b0; #1;
      if (imem_req) begin nreq++; last_addr = imem_addr; end
    end
    chk("stall_nreq", 32'(nreq), 32'd4);
    chk("stall_last", last_addr, 32'hC);
    chk("stall_req",  {31'd0, imem_req},  32'd0);
    chk("stall_head", out_pc, 32'h0);
    tick(); out_ready = 1'b1; #1;
    chk("rel_req",  {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h10);
    chk("rel_pc",   out_pc, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick(); #1;
      chk("drain_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_pc",    out_pc, 32'(4 * k));
    end

    // PC wrap at top of address space
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    tick(); redirect = 1'b0; #1; chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick(); #1; chk("wrap_addr1", imem_addr, 32'h0);
    tick(); #1; chk("wrap_pc0",   out_pc, 32'hFFFF_FFFC);
    tick(); #1; chk("wrap_pc1",   out_pc, 32'h0);

    // perf: 3 redirects, 7 starved cycles after a fresh reset
    tick(); reset = 1'b1; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0; out_ready = 1'b1; #1;                         // c0 starved
    chk("perf_rst_r", perf_redirects,    32'd0);
    chk("perf_rst_e", perf_empty_cycles, 32'd0);
    tick();                                                      // c1 starved
    tick(); redirect = 1'b1; redirect_pc = 32'h40; #1;           // c2 valid
    chk("perf_c2_valid", {31'd0, out_valid}, 32'd1);
    tick(); redirect = 1'b0;                                     // c3 starved
    tick();                                                      // c4 starved
    tick(); redirect = 1'b1; redirect_pc = 32'h80; #1;           // c5 valid
    chk("perf_c5_valid", {31'd0, out_valid}, 32'd1);
    tick(); redirect = 1'b0;                                     // c6 starved
    tick();                                                      // c7 starved
    tick(); redirect = 1'b1; redirect_pc = 32'hC0; #1;           // c8 valid
    chk("perf_c8_valid", {31'd0, out_valid}, 32'd1);
    tick(); redirect = 1'b0;                                     // c9 starved
    tick(); out_ready = 1'b0; #1;
`ifdef PREFETCH_PERF_EN
    exp_redir = 32'd3; exp_empty = 32'd7;
`else
    exp_redir = 32'd0; exp_empty = 32'd0;
`endif
    chk("perf_redirects", perf_redirects,    exp_redir);
    chk("perf_empty",     perf_empty_cycles, exp_empty);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
